// File: rtl/fc_pkg.sv
// Shared types for the forest classifier: node-word layout, FSM states and a feature extractor.
package fc_pkg;
  localparam int FC_WORD_W     = 64;
  localparam int FC_LEAF_BIT   = 63;
  localparam int FC_CLASS_BIT  = 62;
  localparam int FC_FID_LSB    = 59;
  localparam int FC_FID_W      = 3;
  localparam int FC_THR_LSB    = 32;
  localparam int FC_THR_W      = 27;
  localparam int FC_RIGHT_LSB  = 16;
  localparam int FC_LEFT_LSB   = 0;
  localparam int FC_CHILD_W    = 16;

  // feat_id is 3 bits wide, so at most 8 features are addressable.
  localparam int FC_N_FEAT_MAX = 8;
  localparam int FC_FEAT_W_MAX = 64;
  localparam int FC_VEC_W      = FC_N_FEAT_MAX * FC_FEAT_W_MAX;

  typedef struct packed {
    logic                  leaf;
    logic                  cls;
    logic [FC_FID_W-1:0]   feat_id;
    logic [FC_THR_W-1:0]   thr;
    logic [FC_CHILD_W-1:0] right;
    logic [FC_CHILD_W-1:0] left;
  } fc_node_t;

  typedef enum logic [2:0] {
    FC_IDLE,
    FC_FETCH,
    FC_EVAL,
    FC_NEXT,
    FC_OUT
  } fc_state_e;

  function automatic logic [FC_FEAT_W_MAX-1:0] fc_get_feat(
    input logic [FC_VEC_W-1:0] vec,
    input logic [FC_FID_W-1:0] idx,
    input int                  feat_w
  );
    logic [FC_FEAT_W_MAX-1:0] mask;
    mask = (feat_w >= FC_FEAT_W_MAX) ? '1
         : ((FC_FEAT_W_MAX'(1) << feat_w) - FC_FEAT_W_MAX'(1));
    return FC_FEAT_W_MAX'(vec >> (int'(idx) * feat_w)) & mask;
  endfunction
endpackage

// File: rtl/forest_classifier_if.sv
// Feature/config/result bus of the forest classifier.
// FC_PERF_CNT_EN adds the perf_total/perf_attack/perf_err counters.
interface forest_classifier_if #(
  parameter int N_TREES     = 4,
  parameter int NODES_PER_T = 256,
  parameter int N_FEAT      = 6,
  parameter int FEAT_W      = 32
);
  localparam int CFG_AW = $clog2(N_TREES * NODES_PER_T);

  logic                     in_valid;
  logic                     in_ready;
  logic [N_FEAT*FEAT_W-1:0] in_feat;
  logic                     cfg_we;
  logic [CFG_AW-1:0]        cfg_addr;
  logic [63:0]              cfg_data;
  logic                     cfg_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic                     is_attack;
  logic [4:0]               vote_cnt;
  logic                     err;
  logic [N_TREES-1:0]       err_mask;
`ifdef FC_PERF_CNT_EN
  logic [31:0]              perf_total;
  logic [31:0]              perf_attack;
  logic [31:0]              perf_err;
`endif

  modport master (
    output in_valid, in_feat, cfg_we, cfg_addr, cfg_data, out_ready,
    input  in_ready, cfg_ready, out_valid, is_attack, vote_cnt, err, err_mask
`ifdef FC_PERF_CNT_EN
    , input perf_total, perf_attack, perf_err
`endif
  );

  modport slave (
    input  in_valid, in_feat, cfg_we, cfg_addr, cfg_data, out_ready,
    output in_ready, cfg_ready, out_valid, is_attack, vote_cnt, err, err_mask
`ifdef FC_PERF_CNT_EN
    , output perf_total, perf_attack, perf_err
`endif
  );
endinterface

// File: rtl/fc_node_mem.sv
// Node storage for all trees: one write port, one registered read port, contents not reset.
module fc_node_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && int'(waddr) < DEPTH) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/forest_classifier.sv
// Sequential random-forest evaluator: walks each tree from its root and majority-votes attack.
// FC_PERF_CNT_EN adds saturating handshake counters for total/attack/error results.
module forest_classifier
  import fc_pkg::*;
#(
  parameter int N_TREES     = 4,
  parameter int NODES_PER_T = 256,
  parameter int N_FEAT      = 6,
  parameter int FEAT_W      = 32,
  parameter int MAX_DEPTH   = 50,
  parameter int VOTE_THRESH = 3
) (
  input logic               clk,
  input logic               rst_n,
  forest_classifier_if.slave bus
);
  localparam int ADDR_W  = $clog2(NODES_PER_T);
  localparam int MEM_D   = N_TREES * NODES_PER_T;
  localparam int MEM_AW  = $clog2(MEM_D);
  localparam int TREE_W  = (N_TREES > 1) ? $clog2(N_TREES) : 1;
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  fc_state_e                state_q, state_d;
  logic [TREE_W-1:0]        tree_q, tree_d;
  logic [ADDR_W-1:0]        node_q, node_d;
  logic [DEPTH_W-1:0]       depth_q, depth_d;
  logic [4:0]               votes_q, votes_d;
  logic [N_TREES-1:0]       emask_q, emask_d;
  logic [N_FEAT*FEAT_W-1:0] feat_q;

  logic                     accept, mem_we;
  logic [MEM_AW-1:0]        rd_addr;
  logic [63:0]              rd_data;
  fc_node_t                 nd;
  logic [FC_VEC_W-1:0]      feat_pad;
  logic [FC_FEAT_W_MAX-1:0] fv;
  logic [FC_CHILD_W-1:0]    child;

  // Config writes win over a simultaneous vector in IDLE.
  assign accept = (state_q == FC_IDLE) && bus.in_valid && !bus.cfg_we;
  assign mem_we = (state_q == FC_IDLE) && bus.cfg_we;
  assign rd_addr = MEM_AW'(int'(tree_q) * NODES_PER_T + int'(node_q));

  fc_node_mem #(.DEPTH(MEM_D), .AW(MEM_AW), .DW(64)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign nd       = fc_node_t'(rd_data);
  assign feat_pad = FC_VEC_W'(feat_q);
  assign fv       = fc_get_feat(feat_pad, nd.feat_id, FEAT_W);
  // Threshold is zero-extended, so features above 27 bits always go right.
  assign child    = (fv <= FC_FEAT_W_MAX'(nd.thr)) ? nd.left : nd.right;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FC_IDLE;
      tree_q  <= '0;
      node_q  <= '0;
      depth_q <= '0;
      votes_q <= '0;
      emask_q <= '0;
      feat_q  <= '0;
    end else begin
      state_q <= state_d;
      tree_q  <= tree_d;
      node_q  <= node_d;
      depth_q <= depth_d;
      votes_q <= votes_d;
      emask_q <= emask_d;
      if (accept) feat_q <= bus.in_feat;
    end
  end

  always_comb begin
    state_d = state_q;
    tree_d  = tree_q;
    node_d  = node_q;
    depth_d = depth_q;
    votes_d = votes_q;
    emask_d = emask_q;
    case (state_q)
      FC_IDLE: begin
        if (accept) begin
          tree_d  = '0;
          node_d  = '0;
          depth_d = '0;
          votes_d = '0;
          emask_d = '0;
          state_d = FC_FETCH;
        end
      end
      FC_FETCH: state_d = FC_EVAL;
      FC_EVAL: begin
        state_d = FC_NEXT;
        if (int'(depth_q) == MAX_DEPTH) begin
          emask_d[tree_q] = 1'b1;
        end else if (nd.leaf) begin
          votes_d = votes_q + 5'(nd.cls);
        end else if (int'(nd.feat_id) >= N_FEAT || int'(child) >= NODES_PER_T) begin
          emask_d[tree_q] = 1'b1;
        end else begin
          node_d  = ADDR_W'(child);
          depth_d = depth_q + DEPTH_W'(1);
          state_d = FC_FETCH;
        end
      end
      FC_NEXT: begin
        if (int'(tree_q) == N_TREES - 1) begin
          state_d = FC_OUT;
        end else begin
          tree_d  = tree_q + TREE_W'(1);
          node_d  = '0;
          depth_d = '0;
          state_d = FC_FETCH;
        end
      end
      FC_OUT: if (bus.out_ready) state_d = FC_IDLE;
      default: state_d = FC_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == FC_IDLE);
  assign bus.cfg_ready = (state_q == FC_IDLE);
  assign bus.out_valid = (state_q == FC_OUT);
  assign bus.is_attack = bus.out_valid && (int'(votes_q) >= VOTE_THRESH);
  assign bus.vote_cnt  = bus.out_valid ? votes_q : '0;
  assign bus.err       = bus.out_valid && (|emask_q);
  assign bus.err_mask  = bus.out_valid ? emask_q : '0;

`ifdef FC_PERF_CNT_EN
  logic [31:0] perf_total_q, perf_attack_q, perf_err_q;
  logic        out_hs;

  assign out_hs = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_total_q  <= '0;
      perf_attack_q <= '0;
      perf_err_q    <= '0;
    end else if (out_hs) begin
      if (~&perf_total_q) perf_total_q <= perf_total_q + 32'd1;
      if (bus.is_attack && ~&perf_attack_q) perf_attack_q <= perf_attack_q + 32'd1;
      if (bus.err && ~&perf_err_q) perf_err_q <= perf_err_q + 32'd1;
    end
  end

  assign bus.perf_total  = perf_total_q;
  assign bus.perf_attack = perf_attack_q;
  assign bus.perf_err    = perf_err_q;
`endif
endmodule

// File: tb/tb_forest_classifier.sv
// Bench for forest_classifier: directed tree tables, boundary sequences and randomized forests
// checked against a tree-walking reference model.
module tb_forest_classifier;
  import fc_pkg::*;

  localparam int NT = 4, NPT = 256, NF = 6, FW = 32, MD = 50, VT = 3;
  localparam int CFG_AW = $clog2(NT * NPT);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  forest_classifier_if #(.N_TREES(NT), .NODES_PER_T(NPT), .N_FEAT(NF), .FEAT_W(FW)) bus();

  forest_classifier #(
    .N_TREES(NT), .NODES_PER_T(NPT), .N_FEAT(NF), .FEAT_W(FW),
    .MAX_DEPTH(MD), .VOTE_THRESH(VT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { int votes; logic [NT-1:0] mask; bit att; int lat; } res_t;
  typedef struct { logic [31:0] f2; int votes; bit att; int lat; } vec_t;

  int n_chk = 0, n_err = 0;
  int exp_tot = 0, exp_att = 0, exp_errc = 0;
  logic [63:0] mem_m [NT*NPT];
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_leaf(input bit cls);
    return {1'b1, cls, 62'b0};
  endfunction

  function automatic logic [63:0] mk_int(input int fid, input int thr, input int l, input int r);
    fc_node_t n;
    n = '0;
    n.feat_id = 3'(fid);
    n.thr     = 27'(thr);
    n.left    = 16'(l);
    n.right   = 16'(r);
    return n;
  endfunction

  function automatic logic [NF*FW-1:0] rnd_feat();
    logic [NF*FW-1:0] f;
    for (int k = 0; k < NF; k++)
      f[k*FW +: FW] = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h07FF_FFFF);
    return f;
  endfunction

  function automatic logic [NF*FW-1:0] feat2(input logic [31:0] v);
    logic [NF*FW-1:0] f;
    f = rnd_feat();
    f[2*FW +: FW] = v;
    return f;
  endfunction

  // Reference: walk every tree from its root, counting fetched nodes for the cycle budget.
  function automatic res_t model(input logic [NF*FW-1:0] f);
    res_t r;
    fc_node_t w;
    int node, visited, nxt;
    bit done;
    logic [FW-1:0] fv;
    r.votes = 0; r.mask = '0; r.lat = 1;
    for (int t = 0; t < NT; t++) begin
      node = 0; visited = 0; done = 0;
      while (!done) begin
        w = mem_m[t*NPT + node];
        r.lat += 2;
        if (visited == MD) begin r.mask[t] = 1'b1; done = 1; end
        else if (w.leaf) begin r.votes += int'(w.cls); done = 1; end
        else if (int'(w.feat_id) >= NF) begin r.mask[t] = 1'b1; done = 1; end
        else begin
          fv  = f[int'(w.feat_id)*FW +: FW];
          nxt = (fv <= 32'(w.thr)) ? int'(w.left) : int'(w.right);
          if (nxt >= NPT) begin r.mask[t] = 1'b1; done = 1; end
          else begin node = nxt; visited++; end
        end
      end
      r.lat += 1;
    end
    r.att = (r.votes >= VT);
    return r;
  endfunction

  task automatic cfg_wr(input int t, input int n, input logic [63:0] w, input bit lands);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = CFG_AW'(t*NPT + n);
    bus.cfg_data = w;
    @(posedge clk); #1;
    bus.cfg_we   = 1'b0;
    if (lands) mem_m[t*NPT + n] = w;
  endtask

  task automatic wait_result(input logic [NF*FW-1:0] f, output int lat);
    int cyc;
    bus.in_feat  = f;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 64'(bus.out_valid), 64'(1));
    lat = cyc;
  endtask

  task automatic cmp_out(input string nm, input res_t e);
    chk({nm, "_valid"},  64'(bus.out_valid), 64'(1));
    chk({nm, "_votes"},  64'(bus.vote_cnt),  64'(e.votes));
    chk({nm, "_attack"}, 64'(bus.is_attack), 64'(e.att));
    chk({nm, "_err"},    64'(bus.err),       64'(|e.mask));
    chk({nm, "_mask"},   64'(bus.err_mask),  64'(e.mask));
  endtask

  task automatic ack(input res_t e);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    exp_tot++;
    if (e.att) exp_att++;
    if (|e.mask) exp_errc++;
    chk("out_valid_drop", 64'(bus.out_valid), 64'(0));
    chk("in_ready_back", 64'(bus.in_ready), 64'(1));
  endtask

  task automatic do_vec(input string nm, input logic [NF*FW-1:0] f, input res_t e);
    int lat;
    wait_result(f, lat);
    chk({nm, "_latency"}, 64'(lat), 64'(e.lat));
    cmp_out(nm, e);
    ack(e);
  endtask

  task automatic chk_perf();
`ifdef FC_PERF_CNT_EN
    chk("perf_total",  64'(bus.perf_total),  64'(exp_tot));
    chk("perf_attack", 64'(bus.perf_attack), 64'(exp_att));
    chk("perf_err",    64'(bus.perf_err),    64'(exp_errc));
`endif
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not end, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    res_t e;
    logic [NF*FW-1:0] f;
    logic [3:0] cls;
    int lat, seen;

    tbl[0] = '{32'd100,         4, 1'b1, 21};
    tbl[1] = '{32'd101,         0, 1'b0, 21};
    tbl[2] = '{32'd0,           4, 1'b1, 21};
    tbl[3] = '{32'd99,          4, 1'b1, 21};
    tbl[4] = '{32'hFFFF_FFFF,   0, 1'b0, 21};
    tbl[5] = '{32'h0800_0064,   0, 1'b0, 21};
    tbl[6] = '{32'h07FF_FFFF,   0, 1'b0, 21};

    bus.in_valid = 1'b0; bus.in_feat = '0; bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;   bus.cfg_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
    chk("rst_cfg_ready", 64'(bus.cfg_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_vote_cnt",  64'(bus.vote_cnt),  64'(0));
    chk("rst_is_attack", 64'(bus.is_attack), 64'(0));
    chk("rst_err",       64'(bus.err),       64'(0));
    chk("rst_err_mask",  64'(bus.err_mask),  64'(0));
    chk_perf();

    // One leaf per tree, classes {1,1,0,1}: 4*(2+1)+1 cycles.
    cls = 4'b1011;
    for (int t = 0; t < NT; t++) cfg_wr(t, 0, mk_leaf(cls[t]), 1'b1);
    e = '{3, 4'b0000, 1'b1, 13};
    do_vec("single_leaf", rnd_feat(), e);

    // Every root splits feat2 at 100: left leaf attack, right leaf normal.
    for (int t = 0; t < NT; t++) begin
      cfg_wr(t, 0, mk_int(2, 100, 1, 2), 1'b1);
      cfg_wr(t, 1, mk_leaf(1'b1), 1'b1);
      cfg_wr(t, 2, mk_leaf(1'b0), 1'b1);
    end
    for (int i = 0; i < 7; i++) begin
      e = '{tbl[i].votes, 4'b0000, tbl[i].att, tbl[i].lat};
      do_vec($sformatf("thr_tbl%0d", i), feat2(tbl[i].f2), e);
    end

    // Bad feature index in tree 1's root.
    cfg_wr(1, 0, mk_int(7, 100, 1, 2), 1'b1);
    e = '{3, 4'b0010, 1'b1, 19};
    do_vec("bad_feat", feat2(32'd100), e);
    chk("bad_feat_model", 64'(model(feat2(32'd100)).mask), 64'(4'b0010));

    // Self-loop in tree 0 must hit the depth limit.
    cfg_wr(1, 0, mk_int(2, 100, 1, 2), 1'b1);
    cfg_wr(0, 0, mk_int(0, 0, 0, 0), 1'b1);
    f = feat2(32'd100);
    e = model(f);
    chk("self_loop_model_mask", 64'(e.mask), 64'(4'b0001));
    do_vec("self_loop", f, e);

    // Back-pressure: result held, inputs blocked, config writes dropped.
    cfg_wr(0, 0, mk_leaf(1'b1), 1'b1);
    f = feat2(32'd101);
    e = model(f);
    wait_result(f, lat);
    chk("hold_latency", 64'(lat), 64'(e.lat));
    for (int i = 0; i < 20; i++) begin
      cfg_wr(0, 0, mk_leaf(1'b0), 1'b0);
      cmp_out("hold", e);
      chk("hold_in_ready",  64'(bus.in_ready),  64'(0));
      chk("hold_cfg_ready", 64'(bus.cfg_ready), 64'(0));
    end
    ack(e);
    f = feat2(32'd101);
    e = model(f);
    chk("dropped_model_votes", 64'(e.votes), 64'(1));
    do_vec("after_drop", f, e);
    chk_perf();

    // Write and vector together in IDLE: write lands, vector ignored.
    bus.cfg_we = 1'b1; bus.cfg_addr = CFG_AW'(0); bus.cfg_data = mk_leaf(1'b0);
    bus.in_valid = 1'b1; bus.in_feat = feat2(32'd100);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
    mem_m[0] = mk_leaf(1'b0);
    seen = 0;
    repeat (5) begin
      if (!bus.in_ready || bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("coincident_not_accepted", 64'(seen), 64'(0));
    f = feat2(32'd100);
    e = model(f);
    chk("coincident_model_votes", 64'(e.votes), 64'(3));
    do_vec("coincident", f, e);
    chk_perf();

    // Randomized forests.
    for (int t = 0; t < NT; t++)
      for (int i = 0; i < NPT; i++) begin
        int r, fid, l, rr;
        r = $urandom_range(0, 99);
        if (i >= NPT - 8 || r < 30) cfg_wr(t, i, mk_leaf(1'($urandom_range(0, 1))), 1'b1);
        else begin
          fid = (r < 34) ? $urandom_range(6, 7) : $urandom_range(0, 5);
          l   = i + $urandom_range(1, 8);
          rr  = (r == 34) ? 256 + $urandom_range(0, 500) : i + $urandom_range(1, 8);
          cfg_wr(t, i, mk_int(fid, int'($urandom_range(0, 32'h07FF_FFFF)), l, rr), 1'b1);
        end
      end
    for (int k = 0; k < 30; k++) begin
      f = rnd_feat();
      do_vec($sformatf("rand%0d", k), f, model(f));
    end
    chk_perf();

    // Asynchronous reset mid-evaluation: no result, counters cleared, memory kept.
    bus.in_feat = rnd_feat(); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("async_rst_in_ready",  64'(bus.in_ready),  64'(1));
    @(posedge clk); #1 rst_n = 1'b1;
    exp_tot = 0; exp_att = 0; exp_errc = 0;
    seen = 0;
    repeat (150) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("async_rst_no_result", 64'(seen), 64'(0));
    chk_perf();
    f = rnd_feat();
    do_vec("post_reset", f, model(f));
    chk_perf();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
